// File: rtl/axi4_write_responder_if.sv
// AXI4 write-channel bundle (AW/W/B) shared by the write responder and its initiator.
// WSTRB exists only when AXI_WSTRB_EN is defined.
interface axi4_write_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
`ifdef AXI_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] WSTRB;
`endif
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

`ifdef AXI_WSTRB_EN
  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
`else
  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
`endif
endinterface

// File: rtl/axi4_write_responder.sv
// AXI4 INCR write slave with internal byte-lane memory and a registered backdoor read port.
// Optional byte strobes are enabled by defining AXI_WSTRB_EN.
module axi4_write_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         ARESTN,
  axi4_write_responder_if.slave        bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LG    = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [7:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   drop_q, drop_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]  dbg_data_q;

  logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic                   aw_hs_s;
  logic                   w_hs_s;
  logic                   size_err_s;
  logic [19:0]            span_s;
  logic                   cross_s;
  logic [8:0]             nbytes_s;
  logic [LG-1:0]          off_s;
  logic [BYTES-1:0]       lane_mask_s;
  logic [ADDR_WIDTH-1:0]  word_idx_s;
  logic                   in_range_s;
  logic                   last_beat_s;
  logic                   we_s;

  // Address-phase checks: oversize beats and 4 KB crossings poison the whole burst
  always_comb begin
    aw_hs_s    = bus.AWVALID && awready_q;
    size_err_s = (bus.AWSIZE > 3'(LG));
    span_s     = (20'(bus.AWLEN) + 20'd1) << bus.AWSIZE;
    cross_s    = ((20'(bus.AWADDR[11:0]) + span_s) > 20'd4096);
  end

  // Per-beat decode: word index, range check and the size/offset byte lanes
  always_comb begin
    nbytes_s    = 9'd1 << size_q;
    off_s       = addr_q[LG-1:0] & ~(nbytes_s[LG-1:0] - LG'(1));
    lane_mask_s = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_mask_s[b] = (9'(b) >= 9'(off_s)) && (9'(b) < (9'(off_s) + nbytes_s));
    end
`ifdef AXI_WSTRB_EN
    lane_mask_s = lane_mask_s & bus.WSTRB;
`endif
    word_idx_s  = addr_q >> LG;
    in_range_s  = (32'(word_idx_s) < 32'(MEM_DEPTH));
    w_hs_s      = bus.WVALID && wready_q;
    last_beat_s = (beat_q == len_q);
    we_s        = w_hs_s && !drop_q && in_range_s && ARESTN;
  end

  // Next-state and burst bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    beat_d  = beat_q;
    err_d   = err_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs_s) begin
          state_d = S_DATA;
          addr_d  = bus.AWADDR;
          len_d   = bus.AWLEN;
          size_d  = bus.AWSIZE;
          beat_d  = 8'd0;
          err_d   = size_err_s || cross_s;
          drop_d  = size_err_s || cross_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_hs_s) begin
          addr_d = addr_q + ADDR_WIDTH'(nbytes_s);
          beat_d = beat_q + 8'd1;
          err_d  = err_q || (!drop_q && !in_range_s) || (bus.WLAST != last_beat_s);
          if (bus.WLAST || last_beat_s) begin
            state_d = S_RESP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_RESP: begin
        if (bus.BREADY && bvalid_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every bus output comes straight off a flop
  always_comb begin
    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
    if ((state_d == S_RESP) && err_d) begin
      bresp_d = 2'b10;
    end else begin
      bresp_d = 2'b00;
    end
  end

  // State, control and output registers
  always_ff @(posedge clk) begin
    if (!ARESTN) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      beat_q     <= 8'd0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      dbg_data_q <= mem_q[dbg_addr];
    end
  end

  // Memory array is never reset; a reset mid-burst leaves earlier beats in place
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_mask_s[b]) begin
          mem_q[word_idx_s[IDX_W-1:0]][8*b +: 8] <= bus.WDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_axi4_write_responder.sv
// Scoreboard bench for axi4_write_responder: expected BRESP queued at AW issue, popped on B.
module tb_axi4_write_responder;
  logic        clk;
  logic        ARESTN;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_data;

  axi4_write_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) axi ();

  axi4_write_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
    .clk      (clk),
    .ARESTN   (ARESTN),
    .bus      (axi),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  logic [31:0] wbuf [0:7];
  logic [3:0]  strb_v = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_phase(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    int t = 0;
    axi.AWADDR  = a;
    axi.AWLEN   = l;
    axi.AWSIZE  = s;
    axi.AWVALID = 1'b1;
    while (!axi.AWREADY && t < 50) begin tick(); t++; end
    if (t >= 50) check_eq("aw_timeout", 64'd0, 64'd1);
    tick();
    axi.AWVALID = 1'b0;
    check_eq("wready_lat", 64'(axi.WREADY), 64'd1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic last);
    int t = 0;
    axi.WVALID = 1'b1;
    axi.WDATA  = d;
    axi.WLAST  = last;
`ifdef AXI_WSTRB_EN
    axi.WSTRB  = strb_v;
`endif
    while (!axi.WREADY && t < 50) begin tick(); t++; end
    if (t >= 50) check_eq("w_timeout", 64'd0, 64'd1);
    tick();
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
  endtask

  task automatic b_phase(input int hold);
    int t = 0;
    logic [1:0] e;
    check_eq("bvalid_lat", 64'(axi.BVALID), 64'd1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("bvalid_hold", 64'(axi.BVALID), 64'd1);
      if (exp_q.size() > 0) check_eq("bresp_hold", 64'(axi.BRESP), 64'(exp_q[0]));
    end
    axi.BREADY = 1'b1;
    while (!axi.BVALID && t < 50) begin tick(); t++; end
    if (t >= 50) check_eq("b_timeout", 64'd0, 64'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("bresp", 64'(axi.BRESP), 64'(e));
    end
    tick();
    axi.BREADY = 1'b0;
    check_eq("bvalid_drop", 64'(axi.BVALID), 64'd0);
    check_eq("awready_back", 64'(axi.AWREADY), 64'd1);
  endtask

  // last_at < 0 means WLAST is never asserted
  task automatic do_burst(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                          input int nbeats, input int last_at, input logic [1:0] exp, input int hold);
    exp_q.push_back(exp);
    aw_phase(a, l, s);
    for (int i = 0; i < nbeats; i++) w_beat(wbuf[i], (i == last_at));
    b_phase(hold);
  endtask

  task automatic read_word(input string tag, input logic [9:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    tick();
    check_eq(tag, 64'(dbg_data), 64'(exp));
  endtask

  initial begin
    ARESTN      = 1'b0;
    axi.AWADDR  = 16'h0;
    axi.AWLEN   = 8'd0;
    axi.AWSIZE  = 3'd0;
    axi.AWVALID = 1'b0;
    axi.WDATA   = 32'h0;
    axi.WLAST   = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
`ifdef AXI_WSTRB_EN
    axi.WSTRB   = 4'hF;
`endif
    dbg_addr    = 10'd0;
    repeat (3) tick();
    check_eq("rst_awready", 64'(axi.AWREADY), 64'd0);
    check_eq("rst_wready",  64'(axi.WREADY),  64'd0);
    check_eq("rst_bvalid",  64'(axi.BVALID),  64'd0);
    check_eq("rst_bresp",   64'(axi.BRESP),   64'd0);
    check_eq("rst_dbg",     64'(dbg_data),    64'd0);
    ARESTN = 1'b1;
    tick();
    check_eq("awready_release", 64'(axi.AWREADY), 64'd1);

    // W presented with no address must not be taken
    axi.WVALID = 1'b1;
    axi.WLAST  = 1'b1;
    tick();
    check_eq("idle_wready", 64'(axi.WREADY), 64'd0);
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;

    wbuf[0] = 32'hDEADBEEF;
    do_burst(16'h0010, 8'd0, 3'd2, 1, 0, 2'b00, 0);
    read_word("single_w4", 10'd4, 32'hDEADBEEF);

    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    do_burst(16'h0100, 8'd3, 3'd2, 4, 3, 2'b00, 3);
    for (int i = 0; i < 4; i++) read_word("burst_w", 10'(64 + i), wbuf[i]);

    wbuf[0] = 32'h55667788; wbuf[1] = 32'h99AABBCC;
    do_burst(16'h0200, 8'd1, 3'd2, 2, 1, 2'b00, 0);
    wbuf[0] = 32'hAA000000; wbuf[1] = 32'h000000BB;
    do_burst(16'h0203, 8'd1, 3'd0, 2, 1, 2'b00, 0);
    read_word("narrow_w128", 10'd128, 32'hAA667788);
    read_word("narrow_w129", 10'd129, 32'h99AABBBB);

    wbuf[0] = 32'hC0DE0001; wbuf[1] = 32'hC0DE0002;
    do_burst(16'h0FF8, 8'd1, 3'd2, 2, 1, 2'b00, 0);
    wbuf[0] = 32'hBAD00000; wbuf[1] = 32'hBAD00001;
    wbuf[2] = 32'hBAD00002; wbuf[3] = 32'hBAD00003;
    do_burst(16'h0FF8, 8'd3, 3'd2, 4, 3, 2'b10, 0);
    read_word("x4k_w1022", 10'd1022, 32'hC0DE0001);
    read_word("x4k_w1023", 10'd1023, 32'hC0DE0002);

    wbuf[0] = 32'hE0000000; wbuf[1] = 32'hE0000001;
    do_burst(16'h0300, 8'd3, 3'd2, 2, 1, 2'b10, 0);
    read_word("early_w192", 10'd192, 32'hE0000000);
    read_word("early_w193", 10'd193, 32'hE0000001);

    wbuf[0] = 32'hF0000000; wbuf[1] = 32'hF0000001;
    do_burst(16'h0500, 8'd1, 3'd2, 2, -1, 2'b10, 0);
    read_word("nolast_w321", 10'd321, 32'hF0000001);

    wbuf[0] = 32'h0BADC0DE;
    do_burst(16'h0010, 8'd0, 3'd3, 1, 0, 2'b10, 0);
    read_word("sizeerr_w4", 10'd4, 32'hDEADBEEF);

    wbuf[0] = 32'h77777777;
    do_burst(16'h1000, 8'd0, 3'd2, 1, 0, 2'b10, 0);

    // Reset after two of four beats
    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hA1A1A1A1;
    wbuf[2] = 32'hA2A2A2A2; wbuf[3] = 32'hA3A3A3A3;
    do_burst(16'h0400, 8'd3, 3'd2, 4, 3, 2'b00, 0);
    aw_phase(16'h0400, 8'd3, 3'd2);
    w_beat(32'h5A5A0000, 1'b0);
    w_beat(32'h5A5A0001, 1'b0);
    ARESTN = 1'b0;
    tick();
    check_eq("mid_rst_awready", 64'(axi.AWREADY), 64'd0);
    check_eq("mid_rst_bvalid",  64'(axi.BVALID),  64'd0);
    check_eq("mid_rst_wready",  64'(axi.WREADY),  64'd0);
    ARESTN = 1'b1;
    tick();
    check_eq("mid_rel_awready", 64'(axi.AWREADY), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("mid_no_bvalid", 64'(axi.BVALID), 64'd0);
      tick();
    end
    read_word("mid_w256", 10'd256, 32'h5A5A0000);
    read_word("mid_w257", 10'd257, 32'h5A5A0001);
    read_word("mid_w258", 10'd258, 32'hA2A2A2A2);
    read_word("mid_w259", 10'd259, 32'hA3A3A3A3);
    wbuf[0] = 32'hCAFEF00D;
    do_burst(16'h0408, 8'd0, 3'd2, 1, 0, 2'b00, 0);
    read_word("post_rst_w258", 10'd258, 32'hCAFEF00D);

`ifdef AXI_WSTRB_EN
    wbuf[0] = 32'h12345678;
    do_burst(16'h0600, 8'd0, 3'd2, 1, 0, 2'b00, 0);
    strb_v  = 4'b0101;
    wbuf[0] = 32'hFFFFFFFF;
    do_burst(16'h0600, 8'd0, 3'd2, 1, 0, 2'b00, 0);
    strb_v  = 4'hF;
    read_word("wstrb_w384", 10'd384, 32'h12FF56FF);
`endif

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
